// File: rtl/mcs4_clock_reset_gen_if.sv
// Purpose : core-facing timing bundle of the mcs4 clock/reset generator.
// Latency : pure wiring; every signal is registered inside the generator.
// Backpressure: none; free-running timing outputs, clear_pad is a raw pad input.
// Ports:
//   clear_pad  raw asynchronous clear request from the pad (active-high, may bounce)
//   phi1/phi2  non-overlapping clock phase enables
//   sync       high for the whole of subcycle X3
//   subcycle   current subcycle 0..7 (A1..X3)
//   core_reset conditioned active-high core reset
interface mcs4_clock_reset_gen_if;
  logic       clear_pad;
  logic       phi1;
  logic       phi2;
  logic       sync;
  logic [2:0] subcycle;
  logic       core_reset;

  // Generator side
  modport master (
    input  clear_pad,
    output phi1,
    output phi2,
    output sync,
    output subcycle,
    output core_reset
  );

  // Core / pad side
  modport slave (
    output clear_pad,
    input  phi1,
    input  phi2,
    input  sync,
    input  subcycle,
    input  core_reset
  );
endinterface

// File: rtl/mcs4_clock_reset_gen.sv
// Purpose : two-phase clock enables, 8-subcycle timing, SYNC and conditioned core reset.
// Latency : all outputs registered; core_reset asserts 1 edge after stretch/clear_db, drops on a 7->0 wrap.
// Backpressure: none; counters free-run once the poc release has been synchronised.
// Ports:
//   sysclk   system clock, all flops on its rising edge
//   poc_pad  asynchronous active-high power-on clear
//   bus      mcs4_clock_reset_gen_if.master (clear_pad in; phi1, phi2, sync, subcycle, core_reset out)
module mcs4_clock_reset_gen #(
  parameter int CLK_DIV    = 2,  // sysclk cycles per clock quarter (1..16)
  parameter int POC_CYCLES = 4,  // instruction cycles of reset stretch after poc release (1..255)
  parameter int DEB_CYCLES = 8   // stable sysclk edges before a clear change is accepted (1..255)
) (
  input  logic                         sysclk,
  input  logic                         poc_pad,
  mcs4_clock_reset_gen_if.master       bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       POC_LAST = 8'(POC_CYCLES - 1);
  localparam logic [7:0]       DEB_LAST = 8'(DEB_CYCLES - 1);

  // core_reset controller: HOLD keeps the core in reset, RUN lets it execute.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } rst_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             hold0_q, hold1_q;     // poc release synchroniser (set during poc)
  logic [DIV_W-1:0] div_q;
  logic [1:0]       quarter_q;
  logic [2:0]       sub_q;
  logic             stretch_q;
  logic [7:0]       icyc_q;               // instruction cycles completed during stretch
  logic             csync0_q, csync1_q;   // clear_pad synchroniser
  logic             clear_db_q;
  logic [7:0]       deb_q;
  logic             phi1_q, phi2_q, sync_q, crst_q;
  rst_state_t       state_q;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic             run;
  logic             run_n;
  logic [DIV_W-1:0] div_n;
  logic [1:0]       quarter_n;
  logic [2:0]       sub_n;
  logic             wrap;
  logic             stretch_n;
  logic [7:0]       icyc_n;
  logic             clear_db_n;
  logic [7:0]       deb_n;
  rst_state_t       state_n;

  // run goes high two edges after poc release (E1); run_n is the value it
  // takes on the coming edge, so the phase outputs line up with the counters.
  assign run   = ~hold1_q;
  assign run_n = ~hold0_q;

  // ---------------------------------------------------------------------------
  // Timing counters: div -> quarter -> subcycle
  // ---------------------------------------------------------------------------
  always_comb begin
    div_n     = div_q;
    quarter_n = quarter_q;
    sub_n     = sub_q;
    wrap      = 1'b0;
    if (run) begin
      if (div_q == DIV_LAST) begin
        div_n     = '0;
        quarter_n = quarter_q + 2'd1;
        if (quarter_q == 2'd3) begin
          sub_n = sub_q + 3'd1;           // 7 rolls to 0 with no gap
          wrap  = (sub_q == 3'd7);
        end
      end else begin
        div_n = div_q + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // POC stretch: count whole instruction cycles after release
  // ---------------------------------------------------------------------------
  always_comb begin
    stretch_n = stretch_q;
    icyc_n    = icyc_q;
    if (wrap && stretch_q) begin
      if (icyc_q == POC_LAST) begin
        stretch_n = 1'b0;
        icyc_n    = '0;
      end else begin
        icyc_n = icyc_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clear debounce: any reversion before DEB_CYCLES edges restarts the count
  // ---------------------------------------------------------------------------
  always_comb begin
    clear_db_n = clear_db_q;
    deb_n      = '0;
    if (csync1_q != clear_db_q) begin
      if (deb_q == DEB_LAST) begin
        clear_db_n = csync1_q;
      end else begin
        deb_n = deb_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // core_reset controller
  // Entry uses registered stretch/clear_db (one edge of latency, no boundary
  // wait). Exit looks at the values those flops take on the wrap edge itself,
  // so a stretch expiring on the wrap releases on that wrap, while a clear
  // accepted on that same edge keeps the core held.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_RUN: begin
        if (stretch_q || clear_db_q) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (wrap && !stretch_n && !clear_db_n) state_n = ST_RUN;
      end
      default: state_n = ST_HOLD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      hold0_q    <= 1'b1;
      hold1_q    <= 1'b1;
      div_q      <= '0;
      quarter_q  <= '0;
      sub_q      <= '0;
      stretch_q  <= 1'b1;
      icyc_q     <= '0;
      csync0_q   <= 1'b0;
      csync1_q   <= 1'b0;
      clear_db_q <= 1'b0;
      deb_q      <= '0;
      phi1_q     <= 1'b0;
      phi2_q     <= 1'b0;
      sync_q     <= 1'b0;
      crst_q     <= 1'b1;
      state_q    <= ST_HOLD;
    end else begin
      hold0_q    <= 1'b0;
      hold1_q    <= hold0_q;
      div_q      <= div_n;
      quarter_q  <= quarter_n;
      sub_q      <= sub_n;
      stretch_q  <= stretch_n;
      icyc_q     <= icyc_n;
      csync0_q   <= bus.clear_pad;
      csync1_q   <= csync0_q;
      clear_db_q <= clear_db_n;
      deb_q      <= deb_n;
      // Quarters 1 and 3 are dead time between the phases.
      phi1_q     <= run_n && (quarter_n == 2'd0);
      phi2_q     <= run_n && (quarter_n == 2'd2);
      sync_q     <= run_n && (sub_n == 3'd7);
      crst_q     <= (state_n == ST_HOLD);
      state_q    <= state_n;
    end
  end

  assign bus.phi1       = phi1_q;
  assign bus.phi2       = phi2_q;
  assign bus.sync       = sync_q;
  assign bus.subcycle   = sub_q;
  assign bus.core_reset = crst_q;

endmodule

// File: tb/tb_mcs4_clock_reset_gen.sv
// Purpose : scoreboard bench for mcs4_clock_reset_gen (defaults, CLK_DIV=1, CLK_DIV=16).
// Latency : expectations are stamped with the sysclk edge count after which they must hold.
// Backpressure: n/a; outputs sampled on the falling edge or on an explicit mid-cycle trigger.
module tb_mcs4_clock_reset_gen;

  logic sysclk  = 1'b0;
  logic poc_pad = 1'b1;   // default-parameter instance
  logic poc_b   = 1'b1;   // CLK_DIV=1 / CLK_DIV=16 instances
  int   cyc     = 0;      // rising edges seen so far

  int vectors     = 0;
  int miscompares = 0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  mcs4_clock_reset_gen_if if0 ();
  mcs4_clock_reset_gen_if if1 ();
  mcs4_clock_reset_gen_if if2 ();

  mcs4_clock_reset_gen #(.CLK_DIV(2), .POC_CYCLES(4), .DEB_CYCLES(8)) u0 (
    .sysclk (sysclk), .poc_pad (poc_pad), .bus (if0));
  mcs4_clock_reset_gen #(.CLK_DIV(1), .POC_CYCLES(4), .DEB_CYCLES(8)) u1 (
    .sysclk (sysclk), .poc_pad (poc_b), .bus (if1));
  mcs4_clock_reset_gen #(.CLK_DIV(16), .POC_CYCLES(4), .DEB_CYCLES(8)) u2 (
    .sysclk (sysclk), .poc_pad (poc_b), .bus (if2));

  localparam int S_PHI1 = 0, S_PHI2 = 1, S_SYNC = 2, S_SUB = 3, S_CRST = 4;
  string sig_name [5] = '{"phi1", "phi2", "sync", "subcycle", "core_reset"};

  typedef struct {
    int cyc;
    int sig;
    int val;
  } sb_t;
  sb_t  sbq [$];
  event chk_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_PHI1:  return {31'b0, if0.phi1};
      S_PHI2:  return {31'b0, if0.phi2};
      S_SYNC:  return {31'b0, if0.sync};
      S_SUB:   return {29'b0, if0.subcycle};
      default: return {31'b0, if0.core_reset};
    endcase
  endfunction

  task automatic exp_at(input int c, input int s, input int v);
    sb_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic exp_reset_vals(input int c);
    exp_at(c, S_PHI1, 0); exp_at(c, S_PHI2, 0); exp_at(c, S_SYNC, 0);
    exp_at(c, S_SUB, 0);  exp_at(c, S_CRST, 1);
  endtask

  // Default timing (CLK_DIV=2, POC_CYCLES=4) relative to release edge E1.
  task automatic sched_main(input int e1);
    exp_at(e1 - 1, S_PHI1, 0); exp_at(e1, S_PHI1, 1);
    exp_at(e1 + 1, S_PHI1, 1); exp_at(e1 + 2, S_PHI1, 0);
    exp_at(e1 + 3, S_PHI2, 0); exp_at(e1 + 4, S_PHI2, 1);
    exp_at(e1 + 5, S_PHI2, 1); exp_at(e1 + 6, S_PHI2, 0);
    exp_at(e1 + 8, S_SUB, 1);
    exp_at(e1 + 55, S_SYNC, 0); exp_at(e1 + 56, S_SYNC, 1);
    exp_at(e1 + 56, S_SUB, 7);  exp_at(e1 + 63, S_SYNC, 1);
    exp_at(e1 + 64, S_SYNC, 0); exp_at(e1 + 64, S_SUB, 0);
    exp_at(e1 + 128, S_CRST, 1);
    exp_at(e1 + 255, S_CRST, 1); exp_at(e1 + 256, S_CRST, 0);
  endtask

  // First instruction-cycle boundary (7->0 wrap edge) at or after edge x.
  function automatic int next_wrap(input int e1, input int x);
    return e1 + 64 * ((x - e1 + 63) / 64);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  // Scoreboard monitor: compares every queued expectation stamped with the
  // current edge count, on each falling edge or on a mid-cycle trigger.
  initial begin : sb_monitor
    forever begin
      @(negedge sysclk or chk_ev);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          check($sformatf("%s@%0d", sig_name[sbq[i].sig], sbq[i].cyc),
                sample(sbq[i].sig), sbq[i].val);
          sbq.delete(i);
        end
      end
    end
  end

  // Phase monitor for CLK_DIV=1 (k=0) and CLK_DIV=16 (k=1): 800 subcycles
  // (100 instruction cycles) each, checking phase widths and overlap.
  int   ovl [2];
  logic phase_done = 1'b0;
  initial begin : phase_mon
    int         p1 [2];
    int         p2 [2];
    int         nsub [2];
    logic [2:0] prev [2];
    for (int k = 0; k < 2; k++) begin
      p1[k] = 0; p2[k] = 0; nsub[k] = 0; prev[k] = 3'd0; ovl[k] = 0;
    end
    forever begin
      @(negedge sysclk);
      for (int k = 0; k < 2; k++) begin
        logic       a1, a2;
        logic [2:0] s;
        int         d;
        a1 = (k == 0) ? if1.phi1 : if2.phi1;
        a2 = (k == 0) ? if1.phi2 : if2.phi2;
        s  = (k == 0) ? if1.subcycle : if2.subcycle;
        d  = (k == 0) ? 1 : 16;
        if (nsub[k] < 800) begin
          if (s != prev[k]) begin
            check((k == 0) ? "phi1_width_div1" : "phi1_width_div16", p1[k], d);
            check((k == 0) ? "phi2_width_div1" : "phi2_width_div16", p2[k], d);
            nsub[k]++;
            p1[k] = 0;
            p2[k] = 0;
          end
          if (a1) p1[k]++;
          if (a2) p2[k]++;
          if (a1 && a2) ovl[k]++;
        end
        prev[k] = s;
      end
      if (nsub[0] >= 800 && nsub[1] >= 800) phase_done = 1'b1;
    end
  end

  initial begin : stimulus
    int e1, c, w, x;
    if0.clear_pad = 1'b0;
    if1.clear_pad = 1'b0;
    if2.clear_pad = 1'b0;

    // ---- Reset state, release, default timing ----
    @(negedge sysclk);
    exp_reset_vals(cyc + 1);
    exp_reset_vals(cyc + 2);
    @(negedge sysclk);
    @(negedge sysclk);
    poc_pad = 1'b0;
    poc_b   = 1'b0;
    e1 = cyc + 2;
    sched_main(e1);
    wait_until(e1 + 270);

    // ---- Clear debounce: 7-edge glitch ignored ----
    c = cyc;
    if0.clear_pad = 1'b1;
    exp_at(c + 8, S_CRST, 0); exp_at(c + 11, S_CRST, 0); exp_at(c + 14, S_CRST, 0);
    repeat (7) @(negedge sysclk);
    if0.clear_pad = 1'b0;
    wait_until(e1 + 295);

    // ---- Clear debounce: 20-edge pulse accepted ----
    c = cyc;
    if0.clear_pad = 1'b1;
    exp_at(c + 10, S_CRST, 0);
    exp_at(c + 11, S_CRST, 1);
    w = next_wrap(e1, c + 30);          // clear_db drops at c+30
    exp_at(c + 31, S_CRST, 1);
    exp_at(w - 1, S_CRST, 1);
    exp_at(w - 1, S_SUB, 7);
    exp_at(w - 1, S_SYNC, 1);
    exp_at(w, S_CRST, 0);
    repeat (20) @(negedge sysclk);
    if0.clear_pad = 1'b0;
    wait_until(w + 4);

    // ---- Mid-operation POC while phi2=1 in subcycle 5 ----
    x = next_wrap(e1, cyc) + 44;
    while (cyc < x) begin
      @(posedge sysclk);
      #2;
    end
    exp_at(cyc, S_PHI2, 1);
    exp_at(cyc, S_SUB, 5);
    exp_at(cyc, S_CRST, 0);
    -> chk_ev;
    #1;
    poc_pad = 1'b1;
    #1;
    exp_reset_vals(cyc);
    -> chk_ev;
    #1;
    @(negedge sysclk);
    exp_reset_vals(cyc + 1);
    @(negedge sysclk);
    @(negedge sysclk);
    poc_pad = 1'b0;
    e1 = cyc + 2;
    sched_main(e1);
    wait_until(e1 + 270);

    // ---- Clear held across stretch expiry ----
    poc_pad = 1'b1;
    repeat (3) @(negedge sysclk);
    poc_pad = 1'b0;
    e1 = cyc + 2;
    for (int k = 8; k <= 312; k += 8) exp_at(e1 + k, S_CRST, 1);
    exp_at(e1 + 255, S_CRST, 1);
    exp_at(e1 + 257, S_CRST, 1);
    exp_at(e1 + 319, S_CRST, 1);
    exp_at(e1 + 320, S_CRST, 0);
    wait_until(e1 + 100);
    if0.clear_pad = 1'b1;
    wait_until(e1 + 300);
    if0.clear_pad = 1'b0;
    wait_until(e1 + 330);

    // ---- Wait for the long-run phase monitor, bounded ----
    while (!phase_done && cyc < 60000) @(negedge sysclk);
    check("phase_monitor_done", {31'b0, phase_done}, 1);
    check("overlap_div1", ovl[0], 0);
    check("overlap_div16", ovl[1], 0);
    check("scoreboard_leftover", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcs4_clock_reset_gen.md
Name: mcs4_clock_reset_gen

Overview:
Upstream conditioning stage between the input pads and the mcs4 core. It takes the buffered sysclk, poc_pad and clear_pad signals. It generates the non-overlapping two-phase clock enables (phi1/phi2), the 8-subcycle instruction timing and SYNC. It also produces a clean core_reset that asserts immediately and deasserts only on an instruction-cycle boundary. Every core-facing timing signal comes from this block.

Parameters:
CLK_DIV, 2, sysclk cycles per clock quarter (1..16); one subcycle = 4*CLK_DIV sysclk cycles.
POC_CYCLES, 4, full instruction cycles core_reset stays high after poc_pad release (1..255).
DEB_CYCLES, 8, consecutive stable sysclk cycles needed before a clear_pad change is accepted (1..255).

Ports:
sysclk  input  1  system clock; all flops on rising edge.
poc_pad  input  1  asynchronous active-high reset (power-on clear).
clear_pad  input  1  raw asynchronous clear request, active-high, may bounce.
phi1  output  1  clock phase 1, high in quarter 0 of each subcycle.
phi2  output  1  clock phase 2, high in quarter 2 of each subcycle.
sync  output  1  high for all of subcycle 7 (X3), marking the instruction-cycle end.
subcycle  output  3  current subcycle: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
core_reset  output  1  conditioned active-high reset to the core.

Behaviour:
- Clock and reset:
  - One clock, sysclk.
  - poc_pad is an asynchronous, active-high reset.
  - Every output is driven directly from a flop (Moore); no combinational output paths.
- Reset values while poc_pad=1:
  - phi1=0, phi2=0, sync=0, subcycle=0, core_reset=1.
  - All counters and the clear debounce state are cleared.
- Release synchroniser:
  - A 2-flop chain is asynchronously set while poc_pad=1.
  - Let E0 be the first rising edge with poc_pad=0; run rises at E1.
  - Until run=1, the counters hold at 0 and phi1/phi2 stay 0.
- Timing counters:
  - div counts 0..CLK_DIV-1.
  - quarter counts 0..3 and advances when div wraps.
  - subcycle counts 0..7 and advances when quarter wraps 3→0.
  - subcycle wraps 7→0 with no gap.
- Clock outputs:
  - phi1 = run & quarter==0; phi2 = run & quarter==2.
  - Quarters 1 and 3 are dead time, so phi1 and phi2 never overlap.
  - One instruction cycle is 32*CLK_DIV sysclk cycles.
- sync = run & subcycle==7.
- POC stretch:
  - The instruction-cycle counter increments on each 7→0 subcycle wrap while stretch is active.
  - At the wrap that completes cycle POC_CYCLES, stretch clears.
  - That wrap is edge E1 + POC_CYCLES*32*CLK_DIV.
- Clear path:
  - clear_pad passes through a 2-flop synchroniser, then a debounce counter.
  - clear_db takes the synchronised value only after it has differed from clear_db for DEB_CYCLES consecutive edges.
  - Any reversion earlier resets the counter, so glitches shorter than DEB_CYCLES are ignored.
- core_reset:
  - Assertion: goes 1 at the edge after (stretch | clear_db) becomes 1, with no boundary wait.
  - Deassertion: goes 0 only on a subcycle 7→0 wrap where stretch=0 and clear_db=0. The next cycle therefore starts cleanly at A1.
- Clocks keep running during clear and during the POC stretch.
- Simultaneous events:
  - If clear_db rises on the same edge stretch clears, core_reset stays 1.
  - If clear_db falls mid-cycle, core_reset holds until the next wrap.
- Reset mid-operation:
  - poc_pad=1 at any time forces the reset values asynchronously, including mid-phase.
  - Counters restart from 0 after release, following the same E0/E1 sequence.

Test Plan:
- Defaults, poc_pad released before E0:
  - phi1 high for E1..E1+1.
  - phi2 high for E1+4..E1+5.
  - sync first high at E1+56 for 8 cycles.
  - core_reset falls at E1+256.
- Non-overlap:
  - CLK_DIV=1 and CLK_DIV=16, run 100 instruction cycles.
  - phi1&phi2 is never 1.
  - Each phase is high exactly CLK_DIV cycles per subcycle.
- Clear debounce:
  - 7-cycle clear_pad pulse → core_reset unchanged.
  - 20-cycle pulse → core_reset rises 2+8+1 edges after the pulse start.
  - core_reset falls only at the next 7→0 wrap after clear_db drops.
- Mid-operation POC:
  - Assert poc_pad while phi2=1 and subcycle=5.
  - All outputs reach reset values without waiting for an edge.
  - After release, the sequence repeats the first scenario's timing exactly.
- Overlap of clear and stretch:
  - Hold clear_pad high across the stretch expiry.
  - core_reset stays 1 continuously and falls on the first wrap after clear_db=0.
